// File: rtl/imem_stream_loader.sv
// Byte-stream loader for the instruction memory. It assembles little-endian words and writes them
// into IMEM, then reads the image back against the streamed checksum while holding the CPU in reset.
module imem_stream_loader #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 51200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error,
    output logic              cpu_reset_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN0   = 3'd1;
    localparam logic [2:0] LEN1   = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CSUM   = 3'd4;
    localparam logic [2:0] VERIFY = 3'd5;
    localparam logic [2:0] FIN    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [15:0]       widx_q, widx_d;
    logic [31:0]       wsum_q, wsum_d;
    logic [31:0]       csum_q, csum_d;
    logic [15:0]       ridx_q, ridx_d;
    logic [15:0]       rcnt_q, rcnt_d;
    logic [31:0]       rsum_q, rsum_d;
    logic              rd_pend_q, rd_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        xfer;
    logic [31:0] asm_shift;
    logic [15:0] len_new;
    logic [31:0] rsum_new;

    assign s_ready   = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CSUM);
    assign xfer      = s_valid && s_ready;
    // New byte enters at the top so that byte 0 ends up in bits [7:0] after four shifts.
    assign asm_shift = {s_data, asm_q[31:8]};
    assign len_new   = {s_data, len_q[7:0]};
    assign rsum_new  = rsum_q + mem_readdata;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        widx_d    = widx_q;
        wsum_d    = wsum_q;
        csum_d    = csum_q;
        ridx_d    = ridx_q;
        rcnt_d    = rcnt_q;
        rsum_d    = rsum_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        // A read issued this cycle returns data next cycle; write strobes never produce samples.
        rd_pend_d = (state_q == VERIFY) && cs_q && !we_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 2'd0;
                    wsum_d  = 32'd0;
                    rsum_d  = 32'd0;
                    widx_d  = 16'd0;
                    bcnt_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = LEN0;
                end
            end
            LEN0: begin
                if (xfer) begin
                    len_d   = {8'd0, s_data};
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    len_d = len_new;
                    if ((len_new == 16'd0) || (32'(len_new) > 32'(DEPTH_WORDS))) begin
                        err_d   = 2'd1;
                        state_d = FIN;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_d  = asm_shift;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(widx_q);
                        wdata_d = asm_shift;
                        wsum_d  = wsum_q + asm_shift;
                        widx_d  = widx_q + 16'd1;
                        if (widx_q == len_q - 16'd1) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    asm_d  = asm_shift;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        csum_d = asm_shift;
                        if (asm_shift != wsum_q) begin
                            err_d   = 2'd2;
                            state_d = FIN;
                        end else begin
                            // Address 0 is presented in the very first VERIFY cycle.
                            cs_d    = 1'b1;
                            addr_d  = '0;
                            ridx_d  = 16'd1;
                            rcnt_d  = 16'd0;
                            state_d = VERIFY;
                        end
                    end
                end
            end
            VERIFY: begin
                if (ridx_q < len_q) begin
                    cs_d   = 1'b1;
                    addr_d = ADDR_W'(ridx_q);
                    ridx_d = ridx_q + 16'd1;
                end
                if (rd_pend_q) begin
                    rsum_d = rsum_new;
                    rcnt_d = rcnt_q + 16'd1;
                    if (rcnt_q == len_q - 16'd1) begin
                        if (rsum_new == csum_q) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 2'd3;
                        end
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= 16'd0;
            bcnt_q    <= 2'd0;
            asm_q     <= 32'd0;
            widx_q    <= 16'd0;
            wsum_q    <= 32'd0;
            csum_q    <= 32'd0;
            ridx_q    <= 16'd0;
            rcnt_q    <= 16'd0;
            rsum_q    <= 32'd0;
            rd_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 2'd0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            widx_q    <= widx_d;
            wsum_q    <= wsum_d;
            csum_q    <= csum_d;
            ridx_q    <= ridx_d;
            rcnt_q    <= rcnt_d;
            rsum_q    <= rsum_d;
            rd_pend_q <= rd_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign cpu_reset_req  = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = we_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed/random bench for imem_stream_loader against an IMEM model and a checksum-level reference.
module tb_imem_stream_loader;
    localparam int AW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          busy;
    logic          done;
    logic [1:0]    error;
    logic          cpu_reset_req;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;
    logic          mem_clken;

    always #5 clk = ~clk;

    imem_stream_loader #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .error(error), .cpu_reset_req(cpu_reset_req),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_clken(mem_clken)
    );

    // IMEM model: registered read, optional bit-0 corruption on one address.
    logic [31:0] mem [0:DEPTH-1];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int last_wr = -1;
    int corrupt_addr = -1;

    always @(posedge clk) begin
        if (!reset && mem_chipselect) begin
            if (mem_write) begin
                if (int'(mem_address) < DEPTH) mem[mem_address] <= mem_writedata;
                wr_cnt  <= wr_cnt + 1;
                last_wr <= int'(mem_address);
            end else begin
                rd_cnt <= rd_cnt + 1;
                if (int'(mem_address) < DEPTH)
                    mem_readdata <= mem[mem_address] ^ ((int'(mem_address) == corrupt_addr) ? 32'h1 : 32'h0);
                else
                    mem_readdata <= 32'h0;
            end
        end
    end

    int total = 0;
    int bad = 0;
    logic [31:0] pay [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        while (int'($urandom_range(99)) < gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("sready_timeout", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom);
    endtask

    task automatic do_load(input string tag, input int len, input logic [31:0] cdelta,
                           input int gap, input int corrupt, input bit poke);
        logic [31:0] sum;
        logic [15:0] l16;
        int exp_err, wb, rb, n, miss;
        sum = 32'd0;
        foreach (pay[i]) sum += pay[i];
        if (len == 0 || len > DEPTH)               exp_err = 1;
        else if (cdelta != 32'd0)                  exp_err = 2;
        else if (corrupt >= 0 && corrupt < len)    exp_err = 3;
        else                                       exp_err = 0;
        corrupt_addr = corrupt;
        wb = wr_cnt;
        rb = rd_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({tag, "_cpurst_rise"}, {31'd0, cpu_reset_req}, 32'd1);
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        l16 = len[15:0];
        send_byte(l16[7:0], gap);
        send_byte(l16[15:8], gap);
        if (exp_err != 1) begin
            for (int i = 0; i < len; i++) begin
                if (poke && i == 1) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send_word(pay[i], gap);
            end
            send_word(sum + cdelta, gap);
        end
        n = 0;
        while (busy && n < 8 * len + 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({tag, "_busy_timeout"}, {31'd0, busy}, 32'd0);
        $display("load %s len=%0d error=%0d done=%0d writes=%0d reads=%0d", tag, len, error, done,
                 wr_cnt - wb, rd_cnt - rb);
        chk({tag, "_error"}, {30'd0, error}, 32'(exp_err));
        chk({tag, "_done"}, {31'd0, done}, (exp_err == 0) ? 32'd1 : 32'd0);
        chk({tag, "_sready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_cpurst_rel"}, {31'd0, cpu_reset_req}, 32'd0);
        chk({tag, "_writes"}, 32'(wr_cnt - wb), (exp_err == 1) ? 32'd0 : 32'(len));
        chk({tag, "_reads"}, 32'(rd_cnt - rb), (exp_err == 0 || exp_err == 3) ? 32'(len) : 32'd0);
        if (exp_err != 1) begin
            miss = 0;
            for (int k = 0; k < len; k++) if (mem[k] !== pay[k]) miss++;
            chk({tag, "_mem_content"}, 32'(miss), 32'd0);
            chk({tag, "_last_wr_addr"}, 32'(last_wr), 32'(len - 1));
        end
        corrupt_addr = -1;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sready", {31'd0, s_ready}, 32'd0);
        chk("rst_error", {30'd0, error}, 32'd0);
        chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("rst_be", {28'd0, mem_byteenable}, 32'hF);
        chk("rst_clken", {31'd0, mem_clken}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        pay.delete();
        pay.push_back(32'h11223344);
        pay.push_back(32'hAABBCCDD);
        pay.push_back(32'h00000001);
        do_load("basic3", 3, 32'd0, 0, -1, 1'b1);

        pay.delete();
        do_load("len0", 0, 32'd0, 0, -1, 1'b0);
        do_load("len_over", DEPTH + 1, 32'd0, 0, -1, 1'b0);

        fill_random(DEPTH);
        do_load("len_max", DEPTH, 32'd0, 0, -1, 1'b0);

        fill_random(2);
        do_load("bad_csum", 2, 32'd1, 0, -1, 1'b0);

        fill_random(4);
        do_load("readback", 4, 32'd0, 0, 2, 1'b0);

        // Abort mid-DATA once word 3 has been accepted.
        fill_random(8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'd8, 50);
        send_byte(8'd0, 50);
        for (int i = 0; i < 4; i++) send_word(pay[i], 50);
        reset = 1'b1;
        @(negedge clk);
        $display("abort busy=%0d sready=%0d cs=%0d we=%0d addr=%0h wdata=%0h", busy, s_ready,
                 mem_chipselect, mem_write, mem_address, mem_writedata);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cpurst", {31'd0, cpu_reset_req}, 32'd0);
        chk("abort_sready", {31'd0, s_ready}, 32'd0);
        chk("abort_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("abort_we", {31'd0, mem_write}, 32'd0);
        chk("abort_addr", 32'(mem_address), 32'd0);
        chk("abort_wdata", mem_writedata, 32'd0);
        chk("abort_error", {30'd0, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        do_load("after_abort", 8, 32'd0, 50, -1, 1'b0);

        // start coinciding with reset must not begin a load.
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk("rst_vs_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_vs_start_busy2", {31'd0, busy}, 32'd0);
        chk("rst_vs_start_sready", {31'd0, s_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
